// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor and its resolve queue.
package bp_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int BR_W_DEF  = 1;
  localparam int SAT_W     = 64;

  // Prediction record at the predictor's native branch-number width.
  typedef struct packed {
    logic [BR_W_DEF-1:0] branch;
    logic                taken;
  } bp_entry_t;

  // Counters narrower than SAT_W are zero-extended in and truncated out.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_value);
    logic [SAT_W-1:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bp_sync_fifo.sv
// Generic single-clock FIFO with registered full/empty/count.
// Writes while full and reads while empty are ignored.
module bp_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wr_en,
  input  logic [W-1:0]           i_wr_data,
  input  logic                   i_rd_en,
  output logic [W-1:0]           o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  // Occupancy moves only when exactly one of push/pop happens.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
      2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds issued branch predictions until their in-order outcome arrives, then
// emits a one-cycle training record and keeps saturating accuracy counters.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BR_W  = 1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic [BR_W-1:0]        pred_branch,
  input  logic                   pred_taken,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   upd_valid,
  output logic [BR_W-1:0]        upd_branch,
  output logic                   upd_taken,
  output logic                   upd_mispredict,
  output logic [CNT_W-1:0]       misses,
  output logic [CNT_W-1:0]       total,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_underflow
);

  localparam int               EW        = BR_W + 1;
  localparam logic [SAT_W-1:0] L_CNT_MAX = SAT_W'({CNT_W{1'b1}});

  logic             w_full;
  logic             w_empty;
  logic [EW-1:0]    w_head;
  logic             w_enq;
  logic             w_res;
  logic             w_mispredict;
  logic [SAT_W-1:0] w_total_inc;
  logic [SAT_W-1:0] w_misses_inc;

  logic             r_upd_valid;
  logic [BR_W-1:0]  r_upd_branch;
  logic             r_upd_taken;
  logic             r_upd_mispredict;
  logic [CNT_W-1:0] r_misses;
  logic [CNT_W-1:0] r_total;
  logic             r_err_underflow;

  // Both qualifiers use registered FIFO state, so a same-cycle push is never
  // visible to the resolve side and a same-cycle pop never frees a full slot.
  assign w_enq = pred_valid && !w_full;
  assign w_res = res_valid && !w_empty;

  bp_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_enq),
    .i_wr_data ({pred_branch, pred_taken}),
    .i_rd_en   (w_res),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (occupancy)
  );

  assign w_mispredict = w_head[0] ^ res_taken;
  assign w_total_inc  = sat_inc(SAT_W'(r_total), L_CNT_MAX);
  assign w_misses_inc = sat_inc(SAT_W'(r_misses), L_CNT_MAX);

  // Training record, counters and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd_valid      <= 1'b0;
      r_upd_branch     <= '0;
      r_upd_taken      <= 1'b0;
      r_upd_mispredict <= 1'b0;
      r_misses         <= '0;
      r_total          <= '0;
      r_err_underflow  <= 1'b0;
    end else begin
      r_upd_valid <= w_res;
      if (w_res) begin
        r_upd_branch     <= w_head[EW-1:1];
        r_upd_taken      <= res_taken;
        r_upd_mispredict <= w_mispredict;
        r_total          <= w_total_inc[CNT_W-1:0];
        if (w_mispredict) r_misses <= w_misses_inc[CNT_W-1:0];
      end
      if (res_valid && w_empty) r_err_underflow <= 1'b1;
    end
  end

  assign pred_ready     = !w_full;
  assign upd_valid      = r_upd_valid;
  assign upd_branch     = r_upd_branch;
  assign upd_taken      = r_upd_taken;
  assign upd_mispredict = r_upd_mispredict;
  assign misses         = r_misses;
  assign total          = r_total;
  assign err_underflow  = r_err_underflow;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a default-width instance plus a
// 4-bit-counter instance sharing the same stimulus to exercise saturation.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [0:0]  pred_branch;
  logic        pred_taken;
  logic        res_valid;
  logic        res_taken;

  logic        pred_ready;
  logic        upd_valid;
  logic [0:0]  upd_branch;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] misses;
  logic [31:0] total;
  logic [3:0]  occupancy;
  logic        err_underflow;

  logic        s_pred_ready;
  logic        s_upd_valid;
  logic [0:0]  s_upd_branch;
  logic        s_upd_taken;
  logic        s_upd_mispredict;
  logic [3:0]  s_misses;
  logic [3:0]  s_total;
  logic [3:0]  s_occupancy;
  logic        s_err_underflow;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(8), .BR_W(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_branch(pred_branch), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_branch(upd_branch), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .misses(misses), .total(total),
    .occupancy(occupancy), .err_underflow(err_underflow)
  );

  branch_resolve_queue #(.DEPTH(8), .BR_W(1), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(s_pred_ready),
    .pred_branch(pred_branch), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(s_upd_valid), .upd_branch(s_upd_branch), .upd_taken(s_upd_taken),
    .upd_mispredict(s_upd_mispredict), .misses(s_misses), .total(s_total),
    .occupancy(s_occupancy), .err_underflow(s_err_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic enqueue(input logic b, input logic t);
    pred_valid  = 1'b1;
    pred_branch = b;
    pred_taken  = t;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic t);
    res_valid = 1'b1;
    res_taken = t;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] t2_res;
    logic [3:0] t2_mis;
    logic [3:0] t2_br;
    reset = 1'b0; pred_valid = 1'b0; pred_branch = 1'b0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0;
    t2_res = 4'b1100;
    t2_mis = 4'b1001;
    t2_br  = 4'b1010;

    // Test 1: reset state, single enqueue and resolve
    do_reset();
    chk("rst_ready", 64'(pred_ready), 64'd1);
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("rst_misses", 64'(misses), 64'd0);
    chk("rst_total", 64'(total), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    enqueue(1'b1, 1'b1);
    chk("t1_occ_after_enq", 64'(occupancy), 64'd1);
    chk("t1_no_upd_yet", 64'(upd_valid), 64'd0);
    tick();
    resolve(1'b1);
    chk("t1_upd_valid", 64'(upd_valid), 64'd1);
    chk("t1_upd_branch", 64'(upd_branch), 64'd1);
    chk("t1_upd_taken", 64'(upd_taken), 64'd1);
    chk("t1_mispredict", 64'(upd_mispredict), 64'd0);
    chk("t1_total", 64'(total), 64'd1);
    chk("t1_misses", 64'(misses), 64'd0);
    chk("t1_occ", 64'(occupancy), 64'd0);
    tick();
    chk("t1_upd_pulse_end", 64'(upd_valid), 64'd0);
    chk("t1_branch_hold", 64'(upd_branch), 64'd1);

    // Test 2: four predictions 1,0,1,0 resolved by 0,0,1,1
    do_reset();
    enqueue(1'b0, 1'b1);
    enqueue(1'b1, 1'b0);
    enqueue(1'b0, 1'b1);
    enqueue(1'b1, 1'b0);
    chk("t2_occ4", 64'(occupancy), 64'd4);
    for (int i = 0; i < 4; i++) begin
      resolve(t2_res[i]);
      chk($sformatf("t2_valid_%0d", i), 64'(upd_valid), 64'd1);
      chk($sformatf("t2_mis_%0d", i), 64'(upd_mispredict), 64'(t2_mis[i]));
      chk($sformatf("t2_br_%0d", i), 64'(upd_branch), 64'(t2_br[i]));
    end
    chk("t2_misses", 64'(misses), 64'd2);
    chk("t2_total", 64'(total), 64'd4);
    chk("t2_occ0", 64'(occupancy), 64'd0);

    // Test 3: fill to DEPTH, then resolve with a blocked enqueue
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_ready_%0d", i), 64'(pred_ready), 64'd1);
      enqueue(i[0], i[0]);
    end
    chk("t3_occ8", 64'(occupancy), 64'd8);
    chk("t3_full_ready", 64'(pred_ready), 64'd0);
    pred_valid = 1'b1; pred_branch = 1'b1; pred_taken = 1'b1;
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    pred_valid = 1'b0; res_valid = 1'b0;
    chk("t3_occ7", 64'(occupancy), 64'd7);
    chk("t3_ready_again", 64'(pred_ready), 64'd1);
    chk("t3_upd_valid", 64'(upd_valid), 64'd1);
    chk("t3_upd_branch", 64'(upd_branch), 64'd0);
    chk("t3_mispredict", 64'(upd_mispredict), 64'd0);

    // Test 4: resolve on empty queue with same-cycle enqueue
    do_reset();
    pred_valid = 1'b1; pred_branch = 1'b1; pred_taken = 1'b1;
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    pred_valid = 1'b0; res_valid = 1'b0;
    chk("t4_err", 64'(err_underflow), 64'd1);
    chk("t4_no_upd", 64'(upd_valid), 64'd0);
    chk("t4_occ1", 64'(occupancy), 64'd1);
    chk("t4_total0", 64'(total), 64'd0);
    resolve(1'b1);
    chk("t4_late_upd", 64'(upd_valid), 64'd1);
    chk("t4_late_mis", 64'(upd_mispredict), 64'd0);
    chk("t4_err_sticky", 64'(err_underflow), 64'd1);

    // Test 5: 20 mispredicts; the 4-bit instance must saturate at 15
    do_reset();
    for (int i = 0; i < 20; i++) begin
      enqueue(1'b0, 1'b1);
      resolve(1'b0);
    end
    chk("t5_s_misses", 64'(s_misses), 64'd15);
    chk("t5_s_total", 64'(s_total), 64'd15);
    chk("t5_s_occ", 64'(s_occupancy), 64'd0);
    chk("t5_s_ready", 64'(s_pred_ready), 64'd1);
    chk("t5_s_upd_valid", 64'(s_upd_valid), 64'd1);
    chk("t5_s_mis", 64'(s_upd_mispredict), 64'd1);
    chk("t5_s_taken", 64'(s_upd_taken), 64'd0);
    chk("t5_s_branch", 64'(s_upd_branch), 64'd0);
    chk("t5_s_err", 64'(s_err_underflow), 64'd0);
    chk("t5_misses", 64'(misses), 64'd20);
    chk("t5_total", 64'(total), 64'd20);

    // Test 6: reset with entries queued and res_valid high
    resolve(1'b0);
    chk("t6_err_set", 64'(err_underflow), 64'd1);
    for (int i = 0; i < 6; i++) enqueue(1'b1, 1'b1);
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    chk("t6_pre_occ5", 64'(occupancy), 64'd5);
    chk("t6_pre_upd", 64'(upd_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; res_valid = 1'b0;
    chk("t6_occ0", 64'(occupancy), 64'd0);
    chk("t6_misses0", 64'(misses), 64'd0);
    chk("t6_total0", 64'(total), 64'd0);
    chk("t6_upd0", 64'(upd_valid), 64'd0);
    chk("t6_err0", 64'(err_underflow), 64'd0);
    chk("t6_ready", 64'(pred_ready), 64'd1);
    chk("t6_s_misses0", 64'(s_misses), 64'd0);
    tick();
    chk("t6_occ_stays0", 64'(occupancy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits directly downstream of the one-bit branch predictor.
- Buffers each issued prediction (branch number, predicted direction) until the actual outcome resolves in program order.
- Compares prediction against outcome and emits a one-cycle update/mispredict record for predictor training.
- Keeps running totals of resolved branches and misses for accuracy reporting.

Parameters:
- DEPTH, 8: queue entries; power of two, minimum 2.
- BR_W, 1: branch-number width (same width as the predictor's branchnumber).
- CNT_W, 32: width of the miss and total counters (same width as the predictor's mismatch).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state on the posedge where it is sampled high.
- pred_valid  input  1  prediction offered this cycle.
- pred_ready  output  1  queue can accept; equals !full from registered state only.
- pred_branch  input  BR_W  branch number of the prediction.
- pred_taken  input  1  predicted direction.
- res_valid  input  1  actual outcome for the oldest outstanding branch.
- res_taken  input  1  actual direction.
- upd_valid  output  1  one-cycle pulse: resolved record valid.
- upd_branch  output  BR_W  branch number of the resolved entry.
- upd_taken  output  1  actual direction (training value).
- upd_mispredict  output  1  prediction != outcome.
- misses  output  CNT_W  total mispredicts since reset.
- total  output  CNT_W  total resolved branches since reset.
- occupancy  output  clog2(DEPTH)+1  entries held.
- err_underflow  output  1  sticky; set on res_valid while empty.

Behaviour:
- Reset: pointers = 0 and occupancy = 0, so pred_ready = 1. upd_valid, upd_branch, upd_taken, upd_mispredict, misses, total, err_underflow all 0. Entry contents are don't-care.
- Enqueue: fires when pred_valid && pred_ready. Writes {pred_branch, pred_taken} at the write pointer; the pointer wraps modulo DEPTH.
- Resolve: fires when res_valid && occupancy != 0 (occupancy taken from registered state). Pops the oldest entry. On the next posedge: upd_valid = 1, upd_branch = entry branch, upd_taken = res_taken, upd_mispredict = entry taken ^ res_taken. Latency is 1 cycle from res_valid to the upd_* outputs.
- upd_valid is low in every cycle with no resolve. upd_branch, upd_taken and upd_mispredict hold their last values.
- Counters: total += 1 per resolve; misses += 1 per mispredicting resolve. Both saturate at all-ones and never wrap.
- Empty resolve: res_valid with occupancy == 0 sets err_underflow (cleared only by reset). No pop, no upd_valid, counters unchanged. Applies even if pred_valid is high in the same cycle, because a same-cycle enqueue is never bypassed.
- Full: pred_ready = 0 whenever occupancy == DEPTH, even if a resolve fires in the same cycle; the slot becomes usable the following cycle. A dropped prediction is the producer's responsibility.
- Simultaneous enqueue and resolve on a non-empty, non-full queue: both happen; occupancy is unchanged; pointers advance independently.
- Reset mid-operation: all held entries are discarded. A resolve sampled in the reset cycle produces no update. Counters return to 0.
- Occupancy: +1 on enqueue only, -1 on resolve only, unchanged on both or neither.

Decomposition:
- Shared package bp_pkg holds:
  - localparam CNT_W_DEF = 32
  - typedef bp_entry_t = struct {branch[BR_W-1:0], taken}
  - a saturating-increment function, shared with the predictor's mismatch counter
- One natural sub-module: bp_sync_fifo, a generic synchronous FIFO with DEPTH/width parameters and registered full/empty.
- Compare logic and counters stay in the top module.

Test Plan:
1. Reset, then enqueue (branch 1, taken 1) and resolve res_taken = 1 two cycles later -> upd_valid pulses one cycle after res_valid, upd_mispredict = 0, total = 1, misses = 0.
2. Enqueue 4 entries with predictions 1,0,1,0, then resolve 0,0,1,1 -> upd_mispredict sequence 1,0,0,1 in order, misses = 2, total = 4, occupancy returns to 0.
3. Enqueue 8 entries without resolving -> pred_ready = 0 at occupancy 8. Resolve plus pred_valid in the same cycle -> no enqueue, occupancy = 7, pred_ready = 1 next cycle.
4. res_valid with queue empty and pred_valid = 1 in the same cycle -> err_underflow = 1, no upd_valid, occupancy = 1 afterwards.
5. Preload misses near all-ones (force CNT_W = 4, run 20 mispredicts) -> misses = 15 and total = 15, both held.
6. Assert reset with 5 entries queued and res_valid high -> next cycle occupancy = 0, counters = 0, upd_valid = 0, err_underflow = 0.
